// File: rtl/autosa_csc_ctrl_pkg.sv
// Shared encodings for the CSC dual register-group controller.
package autosa_csc_ctrl_pkg;

   // Number of ping-pong register groups in the CSC
   localparam int unsigned CSC_GROUPS = 2;

   // Per-group status field encodings seen by software
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PENDING = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2
   } state_e;

   // A group is idle unless enabled; an enabled group runs only when it is the consumer
   function automatic logic [1:0] group_status(input logic op_en, input logic is_consumer);
      if (!op_en) begin
         return ST_IDLE;
      end
      return is_consumer ? ST_RUNNING : ST_PENDING;
   endfunction

endpackage

// File: rtl/autosa_csc_watchdog.sv
// Saturating BUSY-cycle watchdog; pulses expire on the last allowed cycle.
module autosa_csc_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned TO_W           = 21
) (
   input  logic autosa_core_clk,
   input  logic autosa_core_rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic            ARMED = (TIMEOUT_CYCLES != 0);

   logic [TO_W-1:0] r_cnt;

   // Count while enabled, restart on clear, hold at all-ones instead of wrapping
   always_ff @(posedge autosa_core_clk) begin
      if (autosa_core_rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && (r_cnt != {TO_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expire = ARMED && enable && (r_cnt == LAST);

endmodule

// File: rtl/autosa_csc_dual_group_ctrl.sv
// CSC ping-pong group sequencer: tracks op_en per group, starts the
// datapath on the consumer group and retires it on done or watchdog abort.
module autosa_csc_dual_group_ctrl
   import autosa_csc_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TO_W           = 21
) (
   input  logic             autosa_core_clk,
   input  logic             autosa_core_rst,
   input  logic             producer,
   input  logic             op_en_set,
   input  logic             err_clr,
   input  logic             dp_done,
   output logic             consumer,
   output logic [1:0]       status_0,
   output logic [1:0]       status_1,
   output logic             op_en_0,
   output logic             op_en_1,
   output logic             dp_start,
   output logic             dp_group,
   output logic             dp_busy,
   output logic [CNT_W-1:0] done_cnt,
   output logic             err_timeout
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [CSC_GROUPS-1:0] r_op_en;
   logic [CSC_GROUPS-1:0] w_op_en_nxt;
   logic                  r_consumer;
   logic [CNT_W-1:0]      r_done_cnt;
   logic                  r_err;
   logic                  w_retire;
   logic                  w_abort;
   logic                  w_expire;

   autosa_csc_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_watchdog (
      .autosa_core_clk (autosa_core_clk),
      .autosa_core_rst (autosa_core_rst),
      .clear           (r_state == S_START),
      .enable          (r_state == S_BUSY),
      .expire          (w_expire)
   );

   // Next-state: only the consumer group may start; done beats timeout
   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_op_en[r_consumer]) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (dp_done) begin
               w_retire    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_expire) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // op_en update: a set racing the clear of the same group is dropped
   always_comb begin
      w_op_en_nxt = r_op_en;
      for (int g = 0; g < CSC_GROUPS; g++) begin
         if (op_en_set && (producer == 1'(g))) begin
            w_op_en_nxt[g] = 1'b1;
         end
         if ((w_retire || w_abort) && (r_consumer == 1'(g))) begin
            w_op_en_nxt[g] = 1'b0;
         end
      end
   end

   // Sequencer state, group flags, consumer pointer, counters and sticky error
   always_ff @(posedge autosa_core_clk) begin
      if (autosa_core_rst) begin
         r_state    <= S_IDLE;
         r_op_en    <= '0;
         r_consumer <= 1'b0;
         r_done_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op_en <= w_op_en_nxt;
         if (w_retire || w_abort) begin
            r_consumer <= ~r_consumer;
         end
         if (w_retire) begin
            r_done_cnt <= r_done_cnt + 1'b1;
         end
         if (w_abort) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign consumer    = r_consumer;
   assign op_en_0     = r_op_en[0];
   assign op_en_1     = r_op_en[1];
   assign status_0    = group_status(r_op_en[0], r_consumer == 1'b0);
   assign status_1    = group_status(r_op_en[1], r_consumer == 1'b1);
   assign dp_start    = (r_state == S_START);
   assign dp_busy     = (r_state == S_START) || (r_state == S_BUSY);
   // consumer only toggles on exit from BUSY, so it is stable for the whole layer
   assign dp_group    = r_consumer;
   assign done_cnt    = r_done_cnt;
   assign err_timeout = r_err;

endmodule

// File: tb/tb_autosa_csc_dual_group_ctrl.sv
// Bench for the CSC dual-group controller: a scoreboard of expected dp_start
// events (cycle and group) drained by a monitor, plus directed state checks.
module tb_autosa_csc_dual_group_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int   at;
      logic grp;
   } start_t;
   start_t sb[$];

   // main DUT, default watchdog
   logic        rst = 1'b1, producer = 1'b0, op_en_set = 1'b0, err_clr = 1'b0, dp_done = 1'b0;
   logic        consumer, op_en_0, op_en_1, dp_start, dp_group, dp_busy, err_timeout;
   logic [1:0]  status_0, status_1;
   logic [15:0] done_cnt;

   autosa_csc_dual_group_ctrl dut (
      .autosa_core_clk (clk),
      .autosa_core_rst (rst),
      .producer        (producer),
      .op_en_set       (op_en_set),
      .err_clr         (err_clr),
      .dp_done         (dp_done),
      .consumer        (consumer),
      .status_0        (status_0),
      .status_1        (status_1),
      .op_en_0         (op_en_0),
      .op_en_1         (op_en_1),
      .dp_start        (dp_start),
      .dp_group        (dp_group),
      .dp_busy         (dp_busy),
      .done_cnt        (done_cnt),
      .err_timeout     (err_timeout)
   );

   // second DUT with a short watchdog
   logic        t_rst = 1'b1, t_producer = 1'b0, t_op_en_set = 1'b0, t_err_clr = 1'b0;
   logic        t_dp_done = 1'b0;
   logic        t_consumer, t_op_en_0, t_op_en_1, t_dp_start, t_dp_group, t_dp_busy, t_err;
   logic [1:0]  t_status_0, t_status_1;
   logic [15:0] t_done_cnt;

   autosa_csc_dual_group_ctrl #(
      .TIMEOUT_CYCLES (8)
   ) dut_to (
      .autosa_core_clk (clk),
      .autosa_core_rst (t_rst),
      .producer        (t_producer),
      .op_en_set       (t_op_en_set),
      .err_clr         (t_err_clr),
      .dp_done         (t_dp_done),
      .consumer        (t_consumer),
      .status_0        (t_status_0),
      .status_1        (t_status_1),
      .op_en_0         (t_op_en_0),
      .op_en_1         (t_op_en_1),
      .dp_start        (t_dp_start),
      .dp_group        (t_dp_group),
      .dp_busy         (t_dp_busy),
      .done_cnt        (t_done_cnt),
      .err_timeout     (t_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic push_start(input int at, input logic grp);
      start_t e;
      e.at  = at;
      e.grp = grp;
      sb.push_back(e);
   endtask

   // Monitor: every dp_start of the main DUT must match the head of the scoreboard
   always @(negedge clk) begin
      if (dp_start) begin
         if (sb.size() == 0) begin
            chk("unexpected_dp_start", 1, 0);
         end else begin
            start_t e;
            e = sb.pop_front();
            chk("dp_start_cycle", cyc, e.at);
            chk("dp_start_group", int'(dp_group), int'(e.grp));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // ---------------- reset state
      do_reset();
      chk("rst_consumer", int'(consumer), 0);
      chk("rst_status_0", int'(status_0), 0);
      chk("rst_status_1", int'(status_1), 0);
      chk("rst_op_en", int'({op_en_1, op_en_0}), 0);
      chk("rst_busy", int'(dp_busy), 0);
      chk("rst_done_cnt", int'(done_cnt), 0);
      chk("rst_err", int'(err_timeout), 0);

      // ---------------- single layer on group 0
      producer  = 1'b0;
      op_en_set = 1'b1;
      push_start(cyc + 2, 1'b0);
      tick();
      op_en_set = 1'b0;
      chk("sl_status_0_running", int'(status_0), 1);
      chk("sl_op_en_0", int'(op_en_0), 1);
      chk("sl_not_busy_yet", int'(dp_busy), 0);
      tick();
      chk("sl_busy_start", int'(dp_busy), 1);
      repeat (9) tick();
      chk("sl_busy_hold", int'(dp_busy), 1);
      dp_done = 1'b1;
      tick();
      dp_done = 1'b0;
      chk("sl_op_en_0_clr", int'(op_en_0), 0);
      chk("sl_consumer", int'(consumer), 1);
      chk("sl_done_cnt", int'(done_cnt), 1);
      chk("sl_status_0_idle", int'(status_0), 0);
      chk("sl_idle", int'(dp_busy), 0);

      // ---------------- ping-pong
      do_reset();
      producer  = 1'b0;
      op_en_set = 1'b1;
      push_start(cyc + 2, 1'b0);
      tick();
      op_en_set = 1'b0;
      tick();
      tick();
      producer  = 1'b1;
      op_en_set = 1'b1;
      tick();
      op_en_set = 1'b0;
      chk("pp_status_1_pending", int'(status_1), 2);
      chk("pp_status_0_running", int'(status_0), 1);
      repeat (3) tick();
      dp_done = 1'b1;
      push_start(cyc + 2, 1'b1);
      tick();
      dp_done = 1'b0;
      chk("pp_status_1_running", int'(status_1), 1);
      chk("pp_status_0_idle", int'(status_0), 0);
      chk("pp_consumer", int'(consumer), 1);
      tick();
      chk("pp_busy_g1", int'(dp_busy), 1);
      repeat (5) tick();
      dp_done = 1'b1;
      tick();
      dp_done = 1'b0;
      chk("pp_done_cnt", int'(done_cnt), 2);
      chk("pp_status_1_idle", int'(status_1), 0);
      chk("pp_consumer_back", int'(consumer), 0);

      // ---------------- out-of-order enable never starts
      do_reset();
      producer  = 1'b1;
      op_en_set = 1'b1;
      tick();
      op_en_set = 1'b0;
      chk("ooo_status_1_pending", int'(status_1), 2);
      repeat (100) tick();
      chk("ooo_consumer", int'(consumer), 0);
      chk("ooo_not_busy", int'(dp_busy), 0);
      chk("ooo_still_pending", int'(status_1), 2);

      // ---------------- set of the running group on its retiring edge is dropped
      do_reset();
      producer  = 1'b0;
      op_en_set = 1'b1;
      push_start(cyc + 2, 1'b0);
      tick();
      op_en_set = 1'b0;
      repeat (4) tick();
      dp_done   = 1'b1;
      op_en_set = 1'b1;
      tick();
      dp_done   = 1'b0;
      op_en_set = 1'b0;
      chk("col_op_en_0_dropped", int'(op_en_0), 0);
      chk("col_status_0", int'(status_0), 0);
      chk("col_done_cnt", int'(done_cnt), 1);
      repeat (5) tick();
      chk("col_no_restart", int'(dp_busy), 0);

      // ---------------- reset mid-BUSY
      producer  = 1'b1;
      op_en_set = 1'b1;
      push_start(cyc + 2, 1'b1);
      tick();
      op_en_set = 1'b0;
      repeat (3) tick();
      chk("mr_busy_before", int'(dp_busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", int'(dp_busy), 0);
      chk("mr_op_en", int'({op_en_1, op_en_0}), 0);
      chk("mr_consumer", int'(consumer), 0);
      chk("mr_done_cnt", int'(done_cnt), 0);
      chk("mr_status", int'({status_1, status_0}), 0);
      dp_done = 1'b1;
      tick();
      dp_done = 1'b0;
      repeat (10) tick();
      chk("mr_late_done_ignored", int'(done_cnt), 0);
      chk("mr_no_start", int'(dp_busy), 0);

      // ---------------- watchdog abort (TIMEOUT_CYCLES=8)
      t_rst = 1'b1;
      tick();
      t_rst = 1'b0;
      t_producer  = 1'b0;
      t_op_en_set = 1'b1;
      tick();
      t_op_en_set = 1'b0;
      chk("to_status_0", int'(t_status_0), 1);
      tick();
      chk("to_dp_start", int'(t_dp_start), 1);
      chk("to_dp_group", int'(t_dp_group), 0);
      tick();
      repeat (7) tick();
      chk("to_busy_before_abort", int'(t_dp_busy), 1);
      chk("to_err_before_abort", int'(t_err), 0);
      tick();
      chk("to_err", int'(t_err), 1);
      chk("to_op_en_0", int'(t_op_en_0), 0);
      chk("to_consumer", int'(t_consumer), 1);
      chk("to_done_cnt", int'(t_done_cnt), 0);
      chk("to_idle", int'(t_dp_busy), 0);
      t_err_clr = 1'b1;
      tick();
      t_err_clr = 1'b0;
      chk("to_err_clr", int'(t_err), 0);

      // ---------------- dp_done on the timeout edge: normal retire
      t_producer  = 1'b1;
      t_op_en_set = 1'b1;
      tick();
      t_op_en_set = 1'b0;
      chk("dt_status_1", int'(t_status_1), 1);
      tick();
      tick();
      repeat (7) tick();
      t_dp_done = 1'b1;
      tick();
      t_dp_done = 1'b0;
      chk("dt_err_stays_0", int'(t_err), 0);
      chk("dt_done_cnt", int'(t_done_cnt), 1);
      chk("dt_consumer", int'(t_consumer), 0);
      chk("dt_op_en_1", int'(t_op_en_1), 0);

      repeat (3) tick();
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
